// File: rtl/ov7670_capture_if.sv
// Camera parallel bus plus frame buffer write port of the OV7670 capture block.
// master = capture engine side, slave = camera/frame buffer side.
interface ov7670_capture_if #(
   parameter int ADDR_W = 19
);
   logic              cam_pclk;
   logic              cam_vsync;
   logic              cam_href;
   logic [7:0]        cam_d;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [11:0]       dout;

   modport master (
      input  cam_pclk,
      input  cam_vsync,
      input  cam_href,
      input  cam_d,
      output we,
      output addr,
      output dout
   );

   modport slave (
      output cam_pclk,
      output cam_vsync,
      output cam_href,
      output cam_d,
      input  we,
      input  addr,
      input  dout
   );
endinterface

// File: rtl/ov7670_capture.sv
// OV7670 RGB444 capture: resyncs the camera bus into clk, pairs bytes into
// 12-bit {R,G,B} words and writes them to a linear frame buffer.
module ov7670_capture #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int ADDR_W   = 19
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   output logic             frame_done,
   output logic             overflow,
   ov7670_capture_if.master bus
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_ACTIVE * V_ACTIVE);

   typedef enum logic {
      WAIT_FRAME,
      ACTIVE
   } state_t;

   state_t state_q, state_d;

   logic [10:0]       s1, s2;
   logic              sync_pclk, sync_vs, sync_href;
   logic [7:0]        sync_d;
   logic              pclk_d, vs_d;
   logic              rise_q, vs_rise_q, vs_fall_q, href_q;
   logic [7:0]        d_q;
   logic              phase;
   logic [3:0]        r;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [11:0]       dout_q;
   logic              start, fin, capture;

   assign sync_pclk = s2[10];
   assign sync_vs   = s2[9];
   assign sync_href = s2[8];
   assign sync_d    = s2[7:0];

   // Edge register keeps href/data aligned with the detected pclk edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1        <= '0;
         s2        <= '0;
         pclk_d    <= 1'b0;
         vs_d      <= 1'b0;
         rise_q    <= 1'b0;
         vs_rise_q <= 1'b0;
         vs_fall_q <= 1'b0;
         href_q    <= 1'b0;
         d_q       <= '0;
      end else begin
         s1        <= {bus.cam_pclk, bus.cam_vsync,
                       bus.cam_href, bus.cam_d};
         s2        <= s1;
         pclk_d    <= sync_pclk;
         vs_d      <= sync_vs;
         rise_q    <= sync_pclk & ~pclk_d;
         vs_rise_q <= sync_vs & ~vs_d;
         vs_fall_q <= ~sync_vs & vs_d;
         href_q    <= sync_href;
         d_q       <= sync_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= WAIT_FRAME;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      fin     = 1'b0;
      case (state_q)
         WAIT_FRAME: begin
            if (vs_fall_q && enable) begin
               state_d = ACTIVE;
               start   = 1'b1;
            end
         end
         ACTIVE: begin
            if (vs_rise_q) begin
               state_d = WAIT_FRAME;
               fin     = 1'b1;
            end
         end
         default: state_d = WAIT_FRAME;
      endcase
   end

   assign capture = (state_q == ACTIVE) && rise_q && href_q;

   // A pixel completing with vs_rise is still written alongside frame_done
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         we_q       <= 1'b0;
         addr_q     <= '0;
         dout_q     <= '0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
         phase      <= 1'b0;
         r          <= '0;
      end else begin
         we_q       <= 1'b0;
         frame_done <= fin;
         if (start) begin
            addr_q   <= '0;
            phase    <= 1'b0;
            overflow <= 1'b0;
         end else begin
            if (we_q) begin
               addr_q <= addr_q + ADDR_W'(1);
            end
            if (!href_q) begin
               phase <= 1'b0;
            end else if (capture) begin
               phase <= ~phase;
               if (!phase) begin
                  r <= d_q[3:0];
               end else if (addr_q == LAST) begin
                  overflow <= 1'b1;
               end else begin
                  dout_q <= {r, d_q};
                  we_q   <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.we   = we_q;
   assign bus.addr = addr_q;
   assign bus.dout = dout_q;
endmodule
